// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit: op encodings, tracking entry,
// store lane steering, load alignment/extension and natural-alignment helpers.
package lsu_pkg;

   localparam int LSU_RD_W_MAX = 8;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } load_op_t;

   typedef enum logic [1:0] {
      SB = 2'd0,
      SH = 2'd1,
      SW = 2'd2
   } store_op_t;

   typedef struct packed {
      logic [LSU_RD_W_MAX-1:0] rd;
      load_op_t                load_op;
      logic [1:0]              off;
   } lsu_ld_entry_t;

   function automatic logic ld_misaligned(load_op_t op, logic [1:0] off);
      case (op)
         LH, LHU: return off[0];
         LW:      return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic st_misaligned(store_op_t op, logic [1:0] off);
      case (op)
         SH:      return off[0];
         SW:      return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Low address bits rounded down to the access size.
   function automatic logic [1:0] ld_nat_off(load_op_t op, logic [1:0] off);
      case (op)
         LH, LHU: return {off[1], 1'b0};
         LW:      return 2'b00;
         default: return off;
      endcase
   endfunction

   function automatic logic [1:0] st_nat_off(store_op_t op, logic [1:0] off);
      case (op)
         SH:      return {off[1], 1'b0};
         SW:      return 2'b00;
         default: return off;
      endcase
   endfunction

   function automatic logic [3:0] st_mask(store_op_t op, logic [1:0] off);
      case (op)
         SB:      return 4'b0001 << off;
         SH:      return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] st_lanes(store_op_t op, logic [31:0] data);
      case (op)
         SB:      return {4{data[7:0]}};
         SH:      return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic [31:0] ld_align(load_op_t op, logic [1:0] off, logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (op)
         LB:      return {{24{sh[7]}}, sh[7:0]};
         LH:      return {{16{sh[15]}}, sh[15:0]};
         LBU:     return {24'h0, sh[7:0]};
         LHU:     return {16'h0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

endpackage

// File: rtl/lsu_pipe_if.sv
// Execute/memory/writeback signal bundle of the load/store unit; slave = the LSU itself.
// Misalignment trap outputs exist only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_pipe_if #(
   parameter int XLEN = 32,
   parameter int RD_W = 4
);
   import lsu_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic            is_load_op;
   logic            is_store_op;
   load_op_t        load_op;
   store_op_t       store_op;
   logic [RD_W-1:0] rd;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] write_data;
   logic            d_req_valid;
   logic            d_req_ready;
   logic [XLEN-1:0] d_addr;
   logic [3:0]      d_we;
   logic [XLEN-1:0] d_wr_data;
   logic            d_rsp_valid;
   logic [XLEN-1:0] d_rd_data;
   logic            ld_valid;
   logic [RD_W-1:0] ld_rd;
   logic [XLEN-1:0] ld_rd_data;
   logic            busy;
`ifdef LSU_MISALIGN_TRAP_EN
   logic            misalign_exc;
   logic [XLEN-1:0] misalign_addr;
`endif

   modport slave (
`ifdef LSU_MISALIGN_TRAP_EN
      output misalign_exc, misalign_addr,
`endif
      input  req_valid, is_load_op, is_store_op, load_op, store_op, rd, addr, write_data,
      input  d_req_ready, d_rsp_valid, d_rd_data,
      output req_ready, d_req_valid, d_addr, d_we, d_wr_data,
      output ld_valid, ld_rd, ld_rd_data, busy
   );

   modport master (
`ifdef LSU_MISALIGN_TRAP_EN
      input  misalign_exc, misalign_addr,
`endif
      output req_valid, is_load_op, is_store_op, load_op, store_op, rd, addr, write_data,
      output d_req_ready, d_rsp_valid, d_rd_data,
      input  req_ready, d_req_valid, d_addr, d_we, d_wr_data,
      input  ld_valid, ld_rd, ld_rd_data, busy
   );

endinterface

// File: rtl/lsu_ld_fifo.sv
// In-order tracking FIFO of outstanding loads; push ignored when full, pop ignored when empty.
module lsu_ld_fifo
   import lsu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  lsu_ld_entry_t push_dat_i,
   input  logic          pop_i,
   output lsu_ld_entry_t head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   lsu_ld_entry_t    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit: combinational issue to memory, in-order load tracking, registered writeback.
// LSU_MISALIGN_TRAP_EN: misaligned accesses are consumed and trapped instead of force-aligned.
module lsu_pipe
   import lsu_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter int RD_W            = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic     clk,
   input  logic     rst,
   lsu_pipe_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [1:0]       off;
   logic             excluded;
   logic             fifo_full, fifo_empty, push, pop;
   logic [CNT_W-1:0] fifo_count;
   lsu_ld_entry_t    push_ent, head_ent;
   logic             ld_valid_q, ld_valid_d;
   logic [RD_W-1:0]  ld_rd_q, ld_rd_d;
   logic [XLEN-1:0]  ld_rd_data_q, ld_rd_data_d;

   assign off = bus.addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
   logic            misalign_exc_q;
   logic [XLEN-1:0] misalign_addr_q;

   assign excluded = (bus.is_load_op  & ld_misaligned(bus.load_op, off))
                   | (bus.is_store_op & st_misaligned(bus.store_op, off));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_exc_q  <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         misalign_exc_q <= bus.req_valid & excluded;
         if (bus.req_valid & excluded) misalign_addr_q <= bus.addr;
      end
   end

   assign bus.misalign_exc  = misalign_exc_q;
   assign bus.misalign_addr = misalign_addr_q;
`else
   assign excluded = 1'b0;
`endif

   // Excluded accesses are consumed locally; loads stall on a full tracker with no pop bypass.
   assign bus.d_req_valid = bus.req_valid & ~excluded & (bus.is_store_op | ~fifo_full);
   assign bus.req_ready   = excluded | (bus.d_req_ready & (bus.is_store_op | ~fifo_full));
   assign bus.d_addr      = {bus.addr[XLEN-1:2], 2'b00};
   assign bus.d_we        = bus.is_store_op ? st_mask(bus.store_op, st_nat_off(bus.store_op, off))
                                            : 4'b0000;
   assign bus.d_wr_data   = st_lanes(bus.store_op, bus.write_data);

   assign push = bus.req_valid & bus.is_load_op & bus.d_req_ready & ~fifo_full & ~excluded;
   assign pop  = bus.d_rsp_valid & ~fifo_empty;

   always_comb begin
      push_ent         = '0;
      push_ent.rd      = LSU_RD_W_MAX'(bus.rd);
      push_ent.load_op = bus.load_op;
      push_ent.off     = ld_nat_off(bus.load_op, off);
   end

   lsu_ld_fifo #(.DEPTH(MAX_OUTSTANDING)) u_ld_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_ent),
      .pop_i      (pop),
      .head_o     (head_ent),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   always_comb begin
      ld_valid_d   = pop;
      ld_rd_d      = ld_rd_q;
      ld_rd_data_d = ld_rd_data_q;
      if (pop) begin
         ld_rd_d      = RD_W'(head_ent.rd);
         ld_rd_data_d = ld_align(head_ent.load_op, head_ent.off, bus.d_rd_data);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_valid_q   <= 1'b0;
         ld_rd_q      <= '0;
         ld_rd_data_q <= '0;
      end else begin
         ld_valid_q   <= ld_valid_d;
         ld_rd_q      <= ld_rd_d;
         ld_rd_data_q <= ld_rd_data_d;
      end
   end

   assign bus.ld_valid   = ld_valid_q;
   assign bus.ld_rd      = ld_rd_q;
   assign bus.ld_rd_data = ld_rd_data_q;
   assign bus.busy       = (fifo_count != '0);

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: store lanes, load extension, stall/unstall, push+pop wrap,
// mid-flight reset and misaligned handling (both LSU_MISALIGN_TRAP_EN builds).
module tb_lsu_pipe;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   lsu_pipe_if #(.XLEN(32), .RD_W(4)) bus ();

   lsu_pipe #(.XLEN(32), .RD_W(4), .MAX_OUTSTANDING(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // A response must only arrive while a load is outstanding.
   always @(negedge clk) begin
      if (!rst && bus.d_rsp_valid) chk("rsp_needs_outstanding", bus.busy, 32'd1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.req_valid   = 1'b0;
      bus.is_load_op  = 1'b0;
      bus.is_store_op = 1'b0;
   endtask

   task automatic drive_ld(input load_op_t op, input logic [3:0] r, input logic [31:0] a);
      bus.req_valid   = 1'b1;
      bus.is_load_op  = 1'b1;
      bus.is_store_op = 1'b0;
      bus.load_op     = op;
      bus.rd          = r;
      bus.addr        = a;
   endtask

   task automatic drive_st(input store_op_t op, input logic [31:0] a, input logic [31:0] d);
      bus.req_valid   = 1'b1;
      bus.is_load_op  = 1'b0;
      bus.is_store_op = 1'b1;
      bus.store_op    = op;
      bus.addr        = a;
      bus.write_data  = d;
   endtask

   task automatic store_chk(input store_op_t op, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_addr, input logic [3:0] exp_we,
                            input logic [31:0] exp_data, input string tag);
      drive_st(op, a, d);
      #1;
      chk({tag, "_dvld"}, bus.d_req_valid, 32'd1);
      chk({tag, "_rdy"},  bus.req_ready,   32'd1);
      chk({tag, "_daddr"}, bus.d_addr, exp_addr);
      chk({tag, "_we"},   bus.d_we, exp_we);
      chk({tag, "_wdat"}, bus.d_wr_data, exp_data);
      tick();
      drive_idle();
   endtask

   task automatic load_rt(input load_op_t op, input logic [3:0] r, input logic [31:0] a,
                          input logic [31:0] exp_addr, input logic [31:0] w,
                          input logic [31:0] exp, input string tag);
      drive_ld(op, r, a);
      #1;
      chk({tag, "_rdy"},   bus.req_ready, 32'd1);
      chk({tag, "_daddr"}, bus.d_addr, exp_addr);
      chk({tag, "_we"},    bus.d_we, 32'd0);
      tick();
      drive_idle();
      chk({tag, "_busy"}, bus.busy, 32'd1);
      bus.d_rsp_valid = 1'b1;
      bus.d_rd_data   = w;
      #1;
      chk({tag, "_early"}, bus.ld_valid, 32'd0);
      tick();
      bus.d_rsp_valid = 1'b0;
      chk({tag, "_vld"},  bus.ld_valid, 32'd1);
      chk({tag, "_rd"},   bus.ld_rd, {28'h0, r});
      chk({tag, "_data"}, bus.ld_rd_data, exp);
      chk({tag, "_idle"}, bus.busy, 32'd0);
      tick();
      chk({tag, "_pulse"}, bus.ld_valid, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      bus.load_op     = LW;
      bus.store_op    = SW;
      bus.rd          = '0;
      bus.addr        = '0;
      bus.write_data  = '0;
      bus.d_req_ready = 1'b1;
      bus.d_rsp_valid = 1'b0;
      bus.d_rd_data   = '0;
      #12;
      chk("rst_ld_valid", bus.ld_valid, 32'd0);
      chk("rst_ld_rd",    bus.ld_rd, 32'd0);
      chk("rst_ld_data",  bus.ld_rd_data, 32'd0);
      chk("rst_busy",     bus.busy, 32'd0);
      chk("rst_dreq",     bus.d_req_valid, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("rst_mis_exc",  bus.misalign_exc, 32'd0);
      chk("rst_mis_addr", bus.misalign_addr, 32'd0);
`endif
      tick();
      rst = 1'b0;

      store_chk(SB, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, "sb");
      store_chk(SH, 32'h0000_1002, 32'h0000_BEEF, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, "sh");
      store_chk(SW, 32'h0000_1008, 32'hCAFE_F00D, 32'h0000_1008, 4'b1111, 32'hCAFE_F00D, "sw");
      chk("store_no_track", bus.busy, 32'd0);

      load_rt(LB,  4'd2, 32'h0000_2001, 32'h0000_2000, 32'h1234_80FF, 32'hFFFF_FF80, "lb");
      load_rt(LBU, 4'd4, 32'h0000_2001, 32'h0000_2000, 32'h1234_80FF, 32'h0000_0080, "lbu");
      load_rt(LHU, 4'd6, 32'h0000_2002, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_8001, "lhu");

      // Two outstanding fill the tracker; the third stalls until a response drains one.
      drive_ld(LW, 4'd3, 32'h0000_4000);
      tick();
      drive_ld(LW, 4'd5, 32'h0000_4004);
      tick();
      drive_ld(LW, 4'd7, 32'h0000_4008);
      #1;
      chk("stall_rdy",  bus.req_ready, 32'd0);
      chk("stall_dreq", bus.d_req_valid, 32'd0);
      bus.d_rsp_valid = 1'b1;
      bus.d_rd_data   = 32'h1111_1111;
      #1;
      chk("no_bypass_rdy", bus.req_ready, 32'd0);
      tick();
      bus.d_rsp_valid = 1'b0;
      chk("ord0_vld",  bus.ld_valid, 32'd1);
      chk("ord0_rd",   bus.ld_rd, 32'd3);
      chk("ord0_data", bus.ld_rd_data, 32'h1111_1111);
      #1;
      chk("unstall_rdy",  bus.req_ready, 32'd1);
      chk("unstall_dreq", bus.d_req_valid, 32'd1);
      tick();
      drive_idle();
      bus.d_rsp_valid = 1'b1;
      bus.d_rd_data   = 32'h2222_2222;
      tick();
      bus.d_rd_data   = 32'h3333_3333;
      chk("ord1_vld",  bus.ld_valid, 32'd1);
      chk("ord1_rd",   bus.ld_rd, 32'd5);
      chk("ord1_data", bus.ld_rd_data, 32'h2222_2222);
      tick();
      bus.d_rsp_valid = 1'b0;
      chk("ord2_vld",  bus.ld_valid, 32'd1);
      chk("ord2_rd",   bus.ld_rd, 32'd7);
      chk("ord2_data", bus.ld_rd_data, 32'h3333_3333);
      chk("ord_idle",  bus.busy, 32'd0);

      // Steady push+pop at one outstanding for 8 cycles.
      drive_ld(LW, 4'd1, 32'h0000_5000);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive_ld(LW, 4'(i + 2), 32'h0000_5004 + 32'(4 * i));
         bus.d_rsp_valid = 1'b1;
         bus.d_rd_data   = 32'hA000_0000 + 32'(i);
         #1;
         chk("pp_rdy", bus.req_ready, 32'd1);
         tick();
         chk("pp_vld",  bus.ld_valid, 32'd1);
         chk("pp_rd",   bus.ld_rd, 32'(i + 1));
         chk("pp_data", bus.ld_rd_data, 32'hA000_0000 + 32'(i));
         chk("pp_busy", bus.busy, 32'd1);
      end
      drive_idle();
      bus.d_rd_data = 32'hA000_0008;
      tick();
      bus.d_rsp_valid = 1'b0;
      chk("pp_last_rd",   bus.ld_rd, 32'd9);
      chk("pp_last_data", bus.ld_rd_data, 32'hA000_0008);
      chk("pp_idle",      bus.busy, 32'd0);

      // Reset with two loads in flight.
      drive_ld(LW, 4'd10, 32'h0000_7000);
      tick();
      drive_ld(LW, 4'd11, 32'h0000_7004);
      tick();
      drive_idle();
      chk("prerst_busy", bus.busy, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_vld",  bus.ld_valid, 32'd0);
      chk("midrst_busy", bus.busy, 32'd0);
      chk("midrst_rd",   bus.ld_rd, 32'd0);
      chk("midrst_data", bus.ld_rd_data, 32'd0);
      tick();
      rst = 1'b0;
      load_rt(LH, 4'd12, 32'h0000_6002, 32'h0000_6000, 32'h8001_0000, 32'hFFFF_8001, "postrst");

`ifdef LSU_MISALIGN_TRAP_EN
      drive_ld(LW, 4'd6, 32'h0000_3002);
      #1;
      chk("mis_lw_dreq", bus.d_req_valid, 32'd0);
      chk("mis_lw_rdy",  bus.req_ready, 32'd1);
      tick();
      drive_idle();
      chk("mis_lw_exc",  bus.misalign_exc, 32'd1);
      chk("mis_lw_addr", bus.misalign_addr, 32'h0000_3002);
      chk("mis_lw_busy", bus.busy, 32'd0);
      tick();
      chk("mis_lw_pulse", bus.misalign_exc, 32'd0);
      drive_st(SH, 32'h0000_1001, 32'h0000_1234);
      #1;
      chk("mis_sh_dreq", bus.d_req_valid, 32'd0);
      chk("mis_sh_rdy",  bus.req_ready, 32'd1);
      tick();
      drive_idle();
      chk("mis_sh_exc",  bus.misalign_exc, 32'd1);
      chk("mis_sh_addr", bus.misalign_addr, 32'h0000_1001);
      tick();
      chk("mis_sh_pulse", bus.misalign_exc, 32'd0);
`else
      load_rt(LW,  4'd6, 32'h0000_3002, 32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "mis_lw");
      load_rt(LHU, 4'd8, 32'h0000_3003, 32'h0000_3000, 32'hBEEF_1234, 32'h0000_BEEF, "mis_lhu");
      store_chk(SH, 32'h0000_1001, 32'h0000_1234, 32'h0000_1000, 4'b0011, 32'h1234_1234, "mis_sh");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
